// File: rtl/cheriot_tsmap_arbiter.sv
// Arbitrates the single-port revocation map SRAM between the core load filter and the TBRE.
// Optional SECDED check on returned map words: define CHERIOT_TSMAP_INTG_CHECK_EN.
module cheriot_tsmap_arbiter #(
  parameter logic [31:0] HeapBase  = 32'h2001_0000,
  parameter int unsigned TSMapSize = 1024,
  parameter int unsigned MaxWait   = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        core_req_i,
  input  logic [31:0] core_addr_i,
  output logic        core_gnt_o,
  output logic        core_rvalid_o,
  output logic [31:0] core_rdata_o,
  output logic        core_bit_o,
  input  logic        tbre_req_i,
  input  logic [31:0] tbre_addr_i,
  output logic        tbre_gnt_o,
  output logic        tbre_rvalid_o,
  output logic [31:0] tbre_rdata_o,
  output logic        tbre_bit_o,
  output logic        tsmap_cs_o,
  output logic [15:0] tsmap_addr_o,
  input  logic [31:0] tsmap_rdata_i,
  input  logic [6:0]  tsmap_rdata_intg_i,
  output logic        intg_err_o
);

  localparam logic [7:0]  MAX_WAIT  = 8'(MaxWait);
  localparam logic [24:0] MAP_WORDS = 25'(TSMapSize);

  // Handshake: a requester raises req with a stable addr and holds both until the
  // cycle its gnt is high; the response (rvalid/rdata/bit) appears exactly one cycle later.

  typedef enum logic {
    CORE_PRIO = 1'b0,
    TBRE_PRIO = 1'b1
  } prio_e;

  prio_e      state, state_next;
  logic [7:0] wait_cnt, wait_next;

  logic [31:0] sel_addr;
  logic [32:0] diff;
  logic [23:0] word;
  logic        in_range;
  logic        any_gnt;
  logic        unused_low;

  logic        valid_q;
  logic        owner_q;  // 1: TBRE owns the response in flight
  logic        oor_q;
  logic [4:0]  bitpos_q;

  logic [31:0] word_data;
  logic [31:0] resp_data;
  logic        intg_err;
  logic        live;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= CORE_PRIO;
      wait_cnt <= '0;
    end else begin
      state    <= state_next;
      wait_cnt <= wait_next;
    end
  end

  // The priority flip uses the updated count so that TBRE takes the very cycle in
  // which its wait reaches MaxWait, and TBRE_PRIO always lasts a single cycle.
  always_comb begin
    core_gnt_o = 1'b0;
    tbre_gnt_o = 1'b0;
    state_next = state;
    wait_next  = wait_cnt;
    if (!rst_i) begin
      case (state)
        TBRE_PRIO: begin
          tbre_gnt_o = tbre_req_i;
          core_gnt_o = core_req_i && !tbre_req_i;
        end
        default: begin
          core_gnt_o = core_req_i;
          tbre_gnt_o = tbre_req_i && !core_req_i;
        end
      endcase
    end
    if (!tbre_req_i || tbre_gnt_o) begin
      wait_next = '0;
    end else if (wait_cnt < MAX_WAIT) begin
      wait_next = wait_cnt + 8'd1;
    end
    case (state)
      CORE_PRIO: if (wait_next == MAX_WAIT) state_next = TBRE_PRIO;
      TBRE_PRIO: if (tbre_gnt_o || !tbre_req_i) state_next = CORE_PRIO;
      default:   state_next = CORE_PRIO;
    endcase
  end

  // A borrow out of the 33-bit subtraction means the address lies below the heap.
  assign any_gnt    = core_gnt_o || tbre_gnt_o;
  assign sel_addr   = tbre_gnt_o ? tbre_addr_i : core_addr_i;
  assign diff       = {1'b0, sel_addr} - {1'b0, HeapBase};
  assign word       = diff[31:8];
  assign in_range   = !diff[32] && ({1'b0, word} < MAP_WORDS);
  assign unused_low = ^diff[2:0];

  assign tsmap_cs_o   = any_gnt && in_range;
  assign tsmap_addr_o = any_gnt ? word[15:0] : 16'h0000;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q  <= 1'b0;
      owner_q  <= 1'b0;
      oor_q    <= 1'b0;
      bitpos_q <= '0;
    end else begin
      valid_q  <= any_gnt;
      owner_q  <= tbre_gnt_o;
      oor_q    <= !in_range;
      bitpos_q <= diff[7:3];
    end
  end

  assign word_data = oor_q ? 32'h0000_0000 : tsmap_rdata_i;

`ifdef CHERIOT_TSMAP_INTG_CHECK_EN
  function automatic logic [6:0] secded_intg(input logic [31:0] d);
    logic [6:0] p;
    p[0] = ^(d & 32'h2606_BD25);
    p[1] = ^(d & 32'hDEBA_8050);
    p[2] = ^(d & 32'h413D_89AA);
    p[3] = ^(d & 32'h3123_4ED1);
    p[4] = ^(d & 32'hC2C1_323B);
    p[5] = ^(d & 32'h2DCC_624C);
    p[6] = ^(d & 32'h9850_5586);
    return p ^ 7'h2A;
  endfunction

  // A corrupted map word is reported as all-revoked so the filter fails safe.
  assign intg_err  = valid_q && !oor_q && (secded_intg(tsmap_rdata_i) != tsmap_rdata_intg_i);
  assign resp_data = intg_err ? 32'hFFFF_FFFF : word_data;
`else
  logic unused_intg;
  assign unused_intg = ^tsmap_rdata_intg_i;
  assign intg_err    = 1'b0;
  assign resp_data   = word_data;
`endif

  // Reset also squashes a response already in flight.
  assign live = valid_q && !rst_i;

  assign core_rvalid_o = live && !owner_q;
  assign tbre_rvalid_o = live && owner_q;
  assign core_rdata_o  = core_rvalid_o ? resp_data : 32'h0000_0000;
  assign tbre_rdata_o  = tbre_rvalid_o ? resp_data : 32'h0000_0000;
  assign core_bit_o    = core_rvalid_o && resp_data[bitpos_q];
  assign tbre_bit_o    = tbre_rvalid_o && resp_data[bitpos_q];
  assign intg_err_o    = intg_err && !rst_i;

endmodule

// File: tb/tb_cheriot_tsmap_arbiter.sv
// Bench for cheriot_tsmap_arbiter: directed cases from the plan, then randomized traffic
// checked against a behavioural arbitration/translation model and an SRAM model.
module tb_cheriot_tsmap_arbiter;

  localparam logic [31:0] HEAP     = 32'h2001_0000;
  localparam int          WORDS    = 1024;
  localparam int          MAX_WAIT = 8;
`ifdef CHERIOT_TSMAP_INTG_CHECK_EN
  localparam bit INTG_EN = 1'b1;
`else
  localparam bit INTG_EN = 1'b0;
`endif

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        rst;
  logic        core_req, tbre_req;
  logic [31:0] core_addr, tbre_addr;
  logic        core_gnt, tbre_gnt, core_rvalid, tbre_rvalid, core_bit, tbre_bit;
  logic [31:0] core_rdata, tbre_rdata;
  logic        tsmap_cs, intg_err;
  logic [15:0] tsmap_addr;
  logic [31:0] tsmap_rdata = '0;
  logic [6:0]  tsmap_rdata_intg = '0;
  logic        corrupt_intg;

  always #5 clk = ~clk;

  cheriot_tsmap_arbiter dut (
    .clk_i              (clk),
    .rst_i              (rst),
    .core_req_i         (core_req),
    .core_addr_i        (core_addr),
    .core_gnt_o         (core_gnt),
    .core_rvalid_o      (core_rvalid),
    .core_rdata_o       (core_rdata),
    .core_bit_o         (core_bit),
    .tbre_req_i         (tbre_req),
    .tbre_addr_i        (tbre_addr),
    .tbre_gnt_o         (tbre_gnt),
    .tbre_rvalid_o      (tbre_rvalid),
    .tbre_rdata_o       (tbre_rdata),
    .tbre_bit_o         (tbre_bit),
    .tsmap_cs_o         (tsmap_cs),
    .tsmap_addr_o       (tsmap_addr),
    .tsmap_rdata_i      (tsmap_rdata),
    .tsmap_rdata_intg_i (tsmap_rdata_intg),
    .intg_err_o         (intg_err)
  );

  // ---------------- SRAM model ----------------
  logic [31:0] mem [WORDS];

  function automatic logic [6:0] intg_of(input logic [31:0] d);
    return {^(d & 32'h9850_5586), ^(d & 32'h2DCC_624C), ^(d & 32'hC2C1_323B),
            ^(d & 32'h3123_4ED1), ^(d & 32'h413D_89AA), ^(d & 32'hDEBA_8050),
            ^(d & 32'h2606_BD25)} ^ 7'h2A;
  endfunction

  // Unselected cycles return junk so unmasked out-of-range data is visible.
  always @(posedge clk) begin
    if (tsmap_cs) begin
      tsmap_rdata      <= mem[tsmap_addr[9:0]];
      tsmap_rdata_intg <= intg_of(mem[tsmap_addr[9:0]]) ^ {6'b0, corrupt_intg};
    end else begin
      tsmap_rdata      <= $urandom;
      tsmap_rdata_intg <= 7'($urandom);
    end
  end

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;
  int waited  = 0;                 // consecutive cycles TBRE has asked and been refused
  logic [34:0] exp_q[$];           // {intg_err, tbre_owner, bit, rdata}

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock cycle: drive inputs, check DUT against the model at the falling edge.
  task automatic cycle(input logic r, input logic creq, input logic [31:0] caddr,
                       input logic treq, input logic [31:0] taddr, input logic corrupt,
                       output logic cg, output logic tg);
    logic        ecg, etg, have, inr, err, bitv;
    logic [34:0] e;
    logic [31:0] a, off, d;
    rst = r; core_req = creq; core_addr = caddr; tbre_req = treq; tbre_addr = taddr;
    corrupt_intg = corrupt;
    @(negedge clk);
    cg = core_gnt;
    tg = tbre_gnt;
    if (r) begin
      check("rst_core_gnt", 32'(core_gnt), 0);
      check("rst_tbre_gnt", 32'(tbre_gnt), 0);
      check("rst_core_rvalid", 32'(core_rvalid), 0);
      check("rst_tbre_rvalid", 32'(tbre_rvalid), 0);
      check("rst_core_rdata", core_rdata, 0);
      check("rst_tbre_rdata", tbre_rdata, 0);
      check("rst_bits", {30'd0, core_bit, tbre_bit}, 0);
      check("rst_cs", 32'(tsmap_cs), 0);
      check("rst_addr", 32'(tsmap_addr), 0);
      check("rst_intg_err", 32'(intg_err), 0);
      waited = 0;
      exp_q.delete();
    end else begin
      if (waited >= MAX_WAIT) begin
        etg = treq; ecg = creq && !treq;
      end else begin
        ecg = creq; etg = treq && !creq;
      end
      check("core_gnt", 32'(core_gnt), 32'(ecg));
      check("tbre_gnt", 32'(tbre_gnt), 32'(etg));
      have = exp_q.size() > 0;
      e = have ? exp_q.pop_front() : '0;
      check("core_rvalid", 32'(core_rvalid), 32'(have && !e[33]));
      check("tbre_rvalid", 32'(tbre_rvalid), 32'(have && e[33]));
      check("core_rdata", core_rdata, (have && !e[33]) ? e[31:0] : 32'h0);
      check("tbre_rdata", tbre_rdata, (have && e[33]) ? e[31:0] : 32'h0);
      check("core_bit", 32'(core_bit), 32'(have && !e[33] && e[32]));
      check("tbre_bit", 32'(tbre_bit), 32'(have && e[33] && e[32]));
      check("intg_err", 32'(intg_err), 32'(have && e[34]));
      if (ecg || etg) begin
        a   = ecg ? caddr : taddr;
        off = a - HEAP;
        inr = (a >= HEAP) && ((off / 256) < WORDS);
        check("cs", 32'(tsmap_cs), 32'(inr));
        if (inr) check("sram_addr", 32'(tsmap_addr), off / 256);
        err  = INTG_EN && corrupt && inr;
        d    = err ? 32'hFFFF_FFFF : (inr ? mem[off / 256] : 32'h0);
        bitv = d[(off / 8) % 32];
        exp_q.push_back({err, etg, bitv, d});
      end else begin
        check("cs_idle", 32'(tsmap_cs), 0);
      end
      if (treq && !etg) waited = (waited < MAX_WAIT) ? waited + 1 : MAX_WAIT;
      else waited = 0;
    end
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 5))
      0: return HEAP - 32'($urandom_range(1, 64));
      1: return HEAP + 32'(WORDS * 256) + 32'($urandom_range(0, 1000));
      2: return HEAP + 32'((WORDS - 1) * 256) + 32'($urandom_range(0, 255));
      3: return $urandom;
      default: return HEAP + 32'($urandom_range(0, WORDS * 256 - 1));
    endcase
  endfunction

  // Both requesters held high from a clean state: TBRE must win exactly on the 9th cycle.
  task automatic starve_check();
    logic cg, tg;
    int   first_tbre;
    first_tbre = -1;
    for (int i = 0; i < 9; i++) begin
      cycle(0, 1, HEAP + 32'($urandom_range(0, 4095)), 1, HEAP + 32'($urandom_range(0, 4095)),
            0, cg, tg);
      if (tg && first_tbre < 0) first_tbre = i;
    end
    check("starve_first_tbre", 32'(first_tbre), 8);
    cycle(0, 1, HEAP + 32'h100, 1, HEAP + 32'h200, 0, cg, tg);
    check("starve_core_again", 32'(cg), 1);
    cycle(0, 0, 0, 0, 0, 0, cg, tg);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic        cg, tg;
    logic        creq_h, treq_h, r;
    logic [31:0] caddr_h, taddr_h;
    for (int i = 0; i < WORDS; i++) mem[i] = $urandom;
    mem[1] = 32'h0000_0002;
    mem[3] = 32'hA5A5_0003; mem[4] = 32'h0000_00F4; mem[5] = 32'h8000_0005;
    rst = 1; core_req = 0; tbre_req = 0; core_addr = 0; tbre_addr = 0; corrupt_intg = 0;
    @(posedge clk);
    #1;
    // reset with requests pending: nothing may be granted
    cycle(1, 1, HEAP, 1, HEAP, 0, cg, tg);
    cycle(1, 0, 0, 0, 0, 0, cg, tg);

    // single in-range core lookup, word 1 bit 1
    cycle(0, 1, 32'h2001_0108, 0, 0, 0, cg, tg);
    cycle(0, 0, 0, 0, 0, 0, cg, tg);
    // out of range below the heap, at word 1024, and far away
    cycle(0, 1, 32'h2000_FFF8, 0, 0, 0, cg, tg);
    cycle(0, 1, 32'h2005_0000, 0, 0, 0, cg, tg);
    cycle(0, 0, 0, 1, 32'h0000_0040, 0, cg, tg);
    cycle(0, 0, 0, 0, 0, 0, cg, tg);

    starve_check();

    // back-to-back words 3, 4, 5 with no bubble
    cycle(0, 1, HEAP + 32'h300, 0, 0, 0, cg, tg);
    cycle(0, 1, HEAP + 32'h428, 0, 0, 0, cg, tg);
    cycle(0, 1, HEAP + 32'h5F8, 0, 0, 0, cg, tg);
    cycle(0, 0, 0, 0, 0, 0, cg, tg);

    // reset the cycle after a grant drops the response and restores priority state
    cycle(0, 0, 0, 1, HEAP, 0, cg, tg);
    cycle(0, 1, HEAP + 32'h108, 1, HEAP + 32'h208, 0, cg, tg);
    cycle(1, 0, 0, 0, 0, 0, cg, tg);
    cycle(0, 0, 0, 0, 0, 0, cg, tg);
    starve_check();

`ifdef CHERIOT_TSMAP_INTG_CHECK_EN
    cycle(0, 1, 32'h2001_0108, 0, 0, 1, cg, tg);
    cycle(0, 0, 0, 0, 0, 0, cg, tg);
`endif

    // randomized traffic with hold-until-grant requesters
    creq_h = 0; treq_h = 0; caddr_h = 0; taddr_h = 0;
    for (int i = 0; i < 3000; i++) begin
      if (!creq_h && $urandom_range(0, 3) != 0) begin creq_h = 1; caddr_h = rand_addr(); end
      if (!treq_h && $urandom_range(0, 2) != 0) begin treq_h = 1; taddr_h = rand_addr(); end
      r = ($urandom_range(0, 199) == 0);
      cycle(r, creq_h, caddr_h, treq_h, taddr_h, INTG_EN && ($urandom_range(0, 7) == 0), cg, tg);
      if (cg) creq_h = 0;
      if (tg) treq_h = 0;
    end
    cycle(0, 0, 0, 0, 0, 0, cg, tg);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
